// File: rtl/sqrt_pkg.sv
// Shared types and sizing helpers for the iterative non-restoring square root.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } sqrt_state_e;

    function automatic int unsigned calc_rw(input int unsigned data_w);
        return data_w / 32'd2;
    endfunction

    function automatic int unsigned calc_iters(input int unsigned data_w, input int unsigned bpc);
        if (bpc == 32'd0) begin
            return 32'd0;
        end else begin
            return (data_w / 32'd2) / bpc;
        end
    endfunction

endpackage

// File: rtl/sqrt_nr_step.sv
// One non-restoring square-root iteration: consumes one radicand bit pair and
// produces one root bit. Purely combinational.
module sqrt_nr_step #(
    parameter int RW = 16
) (
    input  logic [RW+1:0] p_in,
    input  logic [RW-1:0] q_in,
    input  logic [1:0]    pair,
    output logic [RW+1:0] p_out,
    output logic [RW-1:0] q_out
);

    logic [RW+1:0] shifted_s;

    // The add/subtract choice follows the sign of the incoming remainder; the
    // shifted value may wrap, but modular arithmetic still lands on the right P.
    always_comb begin
        shifted_s = (p_in << 2) | {{RW{1'b0}}, pair};
        if (!p_in[RW+1]) begin
            p_out = shifted_s - {q_in, 2'b01};
        end else begin
            p_out = shifted_s + {q_in, 2'b11};
        end
        q_out = {q_in[RW-2:0], ~p_out[RW+1]};
    end

endmodule

// File: rtl/sqrt_nr_iter.sv
// Multi-cycle integer square root with valid/ready on both sides; resolves
// BITS_PER_CYCLE root bits per clock and returns floor(sqrt(D)) and D - root^2.
module sqrt_nr_iter
    import sqrt_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [calc_rw(DATA_W)-1:0] out_root,
    output logic [calc_rw(DATA_W):0]   out_rem,
    output logic                     busy
);

    localparam int RW    = calc_rw(DATA_W);
    localparam int ITERS = calc_iters(DATA_W, BITS_PER_CYCLE);
    localparam int CNT_W = $clog2(ITERS + 1);

    if ((DATA_W % 2) != 0 || DATA_W < 4 || BITS_PER_CYCLE < 1 ||
        ((DATA_W / 2) % BITS_PER_CYCLE) != 0) begin : g_param_err
        $error("sqrt_nr_iter: illegal DATA_W / BITS_PER_CYCLE combination");
    end

    sqrt_state_e       state_r;
    logic [DATA_W-1:0] d_r;
    logic [RW+1:0]     p_r;
    logic [RW-1:0]     q_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [RW:0]       rem_fix_s;
    logic              accept_s;

    logic [RW+1:0] p_chain_s [0:BITS_PER_CYCLE];
    logic [RW-1:0] q_chain_s [0:BITS_PER_CYCLE];

    assign p_chain_s[0] = p_r;
    assign q_chain_s[0] = q_r;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        sqrt_nr_step #(.RW(RW)) u_step (
            .p_in  (p_chain_s[g]),
            .q_in  (q_chain_s[g]),
            .pair  (d_r[DATA_W-1-2*g -: 2]),
            .p_out (p_chain_s[g+1]),
            .q_out (q_chain_s[g+1])
        );
    end

    assign in_ready = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    assign busy     = (state_r == CALC) || (state_r == FIX);
    assign accept_s = in_valid && in_ready;

    // Final correction: a negative remainder means the last trial overshot by 2Q+1.
    always_comb begin
        if (p_r[RW+1]) begin
            rem_fix_s = p_r[RW:0] + {q_r, 1'b1};
        end else begin
            rem_fix_s = p_r[RW:0];
        end
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            d_r       <= '0;
            p_r       <= '0;
            q_r       <= '0;
            cnt_r     <= '0;
            out_valid <= 1'b0;
            out_root  <= '0;
            out_rem   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        d_r     <= in_data;
                        p_r     <= '0;
                        q_r     <= '0;
                        cnt_r   <= '0;
                        state_r <= CALC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    p_r <= p_chain_s[BITS_PER_CYCLE];
                    q_r <= q_chain_s[BITS_PER_CYCLE];
                    d_r <= d_r << (2 * BITS_PER_CYCLE);
                    if (cnt_r == CNT_W'(ITERS - 1)) begin
                        cnt_r   <= '0;
                        state_r <= FIX;
                    end else begin
                        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                FIX: begin
                    out_root  <= q_r;
                    out_rem   <= rem_fix_s;
                    out_valid <= 1'b1;
                    state_r   <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // in_ready mirrors out_ready here, so a waiting operand starts at once.
                        if (in_valid) begin
                            d_r     <= in_data;
                            p_r     <= '0;
                            q_r     <= '0;
                            cnt_r   <= '0;
                            state_r <= CALC;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_nr_iter.sv
// Directed bench for sqrt_nr_iter: 32-bit/1-bit-per-cycle and 8-bit/2-bits-per-cycle instances.
module tb_sqrt_nr_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv, ir, ov, ordy, busy;
    logic [31:0] id;
    logic [15:0] oroot;
    logic [16:0] orem;

    logic       iv8, ir8, ov8, ordy8, busy8;
    logic [7:0] id8;
    logic [3:0] oroot8;
    logic [4:0] orem8;

    int tests_run    = 0;
    int tests_failed = 0;

    sqrt_nr_iter #(.DATA_W(32), .BITS_PER_CYCLE(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_data(id),
        .out_valid(ov), .out_ready(ordy), .out_root(oroot), .out_rem(orem), .busy(busy)
    );

    sqrt_nr_iter #(.DATA_W(8), .BITS_PER_CYCLE(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
        .out_valid(ov8), .out_ready(ordy8), .out_root(oroot8), .out_rem(orem8), .busy(busy8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one operand into the 32-bit unit and returns result and latency.
    task automatic op32(input logic [31:0] d, output logic [15:0] r, output logic [16:0] m,
                        output int lat);
        int guard;
        guard = 0;
        while (!ir && guard < 64) begin
            tick();
            guard++;
        end
        iv = 1'b1;
        id = d;
        tick();
        iv  = 1'b0;
        id  = 32'hDEAD_BEEF;
        lat = 0;
        while (!ov && lat < 64) begin
            tick();
            lat++;
        end
        r = oroot;
        m = orem;
        if (ordy) tick();
    endtask

    task automatic op8(input logic [7:0] d, output logic [3:0] r, output logic [4:0] m,
                       output int lat);
        iv8 = 1'b1;
        id8 = d;
        tick();
        iv8 = 1'b0;
        id8 = 8'hA5;
        lat = 0;
        while (!ov8 && lat < 16) begin
            tick();
            lat++;
        end
        r = oroot8;
        m = orem8;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({ir, ov, busy, oroot, orem} !== {1'b1, 1'b0, 1'b0, 16'd0, 17'd0}) begin
            tests_failed++;
            $display("FAIL reset32: ir=%0b ov=%0b busy=%0b root=%0d rem=%0d, want 1 0 0 0 0",
                     ir, ov, busy, oroot, orem);
        end
        tests_run++;
        if ({ir8, ov8, busy8, oroot8, orem8} !== {1'b1, 1'b0, 1'b0, 4'd0, 5'd0}) begin
            tests_failed++;
            $display("FAIL reset8: ir=%0b ov=%0b busy=%0b root=%0d rem=%0d, want 1 0 0 0 0",
                     ir8, ov8, busy8, oroot8, orem8);
        end
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (ir !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset: ir=%0b busy=%0b, want 1 0", ir, busy);
        end
    endtask

    task automatic test_small();
        logic [31:0] dv [6] = '{32'd0, 32'd1, 32'd4, 32'd9, 32'd15, 32'd16};
        logic [15:0] rv [6] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd3, 16'd4};
        logic [16:0] mv [6] = '{17'd0, 17'd0, 17'd0, 17'd0, 17'd6, 17'd0};
        logic [15:0] r;
        logic [16:0] m;
        int lat;
        for (int i = 0; i < 6; i++) begin
            op32(dv[i], r, m, lat);
            tests_run++;
            if (r !== rv[i] || m !== mv[i] || lat != 17) begin
                tests_failed++;
                $display("FAIL small D=%0d: root=%0d rem=%0d lat=%0d, want %0d %0d 17",
                         dv[i], r, m, lat, rv[i], mv[i]);
            end
        end
    endtask

    task automatic test_large();
        logic [31:0] dv [4] = '{32'd4294705156, 32'd4294967295, 32'd1048576, 32'd40000};
        logic [15:0] rv [4] = '{16'd65534, 16'd65535, 16'd1024, 16'd200};
        logic [16:0] mv [4] = '{17'd0, 17'd131070, 17'd0, 17'd0};
        logic [15:0] r;
        logic [16:0] m;
        int lat;
        for (int i = 0; i < 4; i++) begin
            op32(dv[i], r, m, lat);
            tests_run++;
            if (r !== rv[i] || m !== mv[i] || lat != 17) begin
                tests_failed++;
                $display("FAIL large D=%0d: root=%0d rem=%0d lat=%0d, want %0d %0d 17",
                         dv[i], r, m, lat, rv[i], mv[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        ordy = 1'b0;
        iv   = 1'b1;
        id   = 32'd255;
        tick();
        iv  = 1'b0;
        lat = 0;
        while (!ov && lat < 64) begin
            tick();
            lat++;
        end
        // A competing operand while the result is stalled must be ignored.
        iv = 1'b1;
        id = 32'd49;
        for (int c = 0; c < 10; c++) begin
            tests_run++;
            if (ov !== 1'b1 || oroot !== 16'd15 || orem !== 17'd30 || ir !== 1'b0) begin
                tests_failed++;
                $display("FAIL hold cyc%0d: ov=%0b root=%0d rem=%0d ir=%0b, want 1 15 30 0",
                         c, ov, oroot, orem, ir);
            end
            tick();
        end
        iv   = 1'b0;
        ordy = 1'b1;
        #1;
        tests_run++;
        if (ir !== 1'b1) begin
            tests_failed++;
            $display("FAIL release_ready: ir=%0b, want 1", ir);
        end
        tick();
        tests_run++;
        if (ov !== 1'b0 || busy !== 1'b0 || ir !== 1'b1 || oroot !== 16'd15) begin
            tests_failed++;
            $display("FAIL after_handshake: ov=%0b busy=%0b ir=%0b root=%0d, want 0 0 1 15",
                     ov, busy, ir, oroot);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] dv [3] = '{32'd100, 32'd169, 32'd256};
        logic [15:0] rv [3] = '{16'd10, 16'd13, 16'd16};
        int lat;
        ordy = 1'b1;
        iv   = 1'b1;
        id   = dv[0];
        tick();
        for (int i = 0; i < 3; i++) begin
            id  = 32'hFFFF_FFFF;
            lat = 0;
            while (!ov && lat < 64) begin
                tick();
                lat++;
            end
            tests_run++;
            if (oroot !== rv[i] || orem !== 17'd0 || lat != 17) begin
                tests_failed++;
                $display("FAIL b2b #%0d: root=%0d rem=%0d lat=%0d, want %0d 0 17",
                         i, oroot, orem, lat, rv[i]);
            end
            if (i < 2) begin
                id = dv[i+1];
            end else begin
                iv = 1'b0;
            end
            tick();
            if (i < 2) begin
                tests_run++;
                if (busy !== 1'b1 || ov !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL b2b_nobubble #%0d: busy=%0b ov=%0b, want 1 0", i, busy, ov);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] r;
        logic [16:0] m;
        int lat;
        iv = 1'b1;
        id = 32'd12345;
        tick();
        iv = 1'b0;
        tick();
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL midop_busy: busy=%0b, want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (ov !== 1'b0 || oroot !== 16'd0 || orem !== 17'd0 || busy !== 1'b0 || ir !== 1'b1) begin
            tests_failed++;
            $display("FAIL midop_reset: ov=%0b root=%0d rem=%0d busy=%0b ir=%0b, want 0 0 0 0 1",
                     ov, oroot, orem, busy, ir);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (ir !== 1'b1 || ov !== 1'b0) begin
            tests_failed++;
            $display("FAIL midop_release: ir=%0b ov=%0b, want 1 0", ir, ov);
        end
        op32(32'd65536, r, m, lat);
        tests_run++;
        if (r !== 16'd256 || m !== 17'd0 || lat != 17) begin
            tests_failed++;
            $display("FAIL midop_next: root=%0d rem=%0d lat=%0d, want 256 0 17", r, m, lat);
        end
    endtask

    task automatic test_exhaustive8();
        logic [3:0] r;
        logic [4:0] m;
        int lat;
        int ref_r;
        int ref_m;
        ordy8 = 1'b1;
        for (int d = 0; d < 256; d++) begin
            ref_r = 0;
            for (int k = 0; k < 16; k++) begin
                if (k * k <= d) ref_r = k;
            end
            ref_m = d - ref_r * ref_r;
            op8(d[7:0], r, m, lat);
            tests_run++;
            if (int'(r) != ref_r || int'(m) != ref_m || lat != 3) begin
                tests_failed++;
                $display("FAIL w8 D=%0d: root=%0d rem=%0d lat=%0d, want %0d %0d 3",
                         d, r, m, lat, ref_r, ref_m);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        iv    = 1'b0;
        id    = 32'd0;
        ordy  = 1'b1;
        iv8   = 1'b0;
        id8   = 8'd0;
        ordy8 = 1'b1;
        test_reset();
        test_small();
        test_large();
        test_backpressure();
        test_back_to_back();
        test_reset_midop();
        test_exhaustive8();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
